// File: rtl/vga_line_buffer_mc.sv
// vga_line_buffer_mc: multi-line VGA line buffer.
// Ring of NUM_LINES line slots in one RAM, programmable active width.
module vga_line_buffer_mc #(
    parameter int PIXEL_W   = 24,
    parameter int MAX_WIDTH = 640,
    parameter int NUM_LINES = 4,
    parameter int CNT_W     = $clog2(MAX_WIDTH + 1),
    parameter int OCC_W     = $clog2(NUM_LINES + 1)
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               cfg_enable,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic               flag_clr,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIXEL_W-1:0] s_data,
    input  logic               s_eol,
    input  logic               rd_line_start,
    input  logic               rd_pix_en,
    output logic [PIXEL_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [OCC_W-1:0]   lines_avail,
    output logic               underflow,
    output logic               rd_abort,
    output logic               short_line
);

    localparam int PTR_W  = $clog2(NUM_LINES);
    localparam int DEPTH  = NUM_LINES * MAX_WIDTH;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0]  MAX_W_C  = CNT_W'(MAX_WIDTH);
    localparam logic [OCC_W-1:0]  FULL_C   = OCC_W'(NUM_LINES);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(MAX_WIDTH);

    typedef enum logic {
        RD_IDLE,
        RD_LINE
    } rd_state_t;

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [PIXEL_W-1:0] ram_q;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  wcol;
    logic [CNT_W-1:0]  rcol;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    rd_state_t         rd_state;

    logic [CNT_W-1:0]  eff_w;
    logic [CNT_W-1:0]  last_col;
    logic              wr_fire;
    logic              wr_last;
    logic              commit;
    logic              short_set;
    logic              reading;
    logic              rd_fire;
    logic              rd_last;
    logic              consume;
    logic              start_next;
    logic              uf_set;
    logic              ab_set;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Effective line width: 0 or out-of-range widths fall back to MAX_WIDTH
    always_comb begin
        eff_w = cfg_width;
        if (cfg_width == '0 || cfg_width > MAX_W_C) begin
            eff_w = MAX_W_C;
        end
    end

    assign last_col = eff_w - CNT_W'(1);
    assign reading  = (rd_state == RD_LINE);

    // Write-side handshake, commit and short-line detection
    always_comb begin
        wr_fire   = s_valid && s_ready && cfg_enable && !ARESET;
        wr_last   = (wcol >= last_col);
        commit    = wr_fire && (wr_last || s_eol);
        short_set = wr_fire && s_eol && !wr_last;
    end

    // Read-side line start, pixel fetch and line consumption
    always_comb begin
        start_next = rd_line_start &&
                     (reading ? (occ > OCC_W'(1)) : (occ != '0));
        uf_set     = rd_line_start && !start_next;
        ab_set     = rd_line_start && reading;
        rd_fire    = reading && rd_pix_en && !rd_line_start &&
                     cfg_enable && !ARESET;
        rd_last    = (rcol >= last_col);
        consume    = (reading && rd_line_start) || (rd_fire && rd_last);
    end

    // Occupancy: commit and consume in one cycle cancel out
    always_comb begin
        occ_nxt = occ;
        if (commit && !consume) begin
            occ_nxt = occ + OCC_W'(1);
        end else if (consume && !commit) begin
            occ_nxt = occ - OCC_W'(1);
        end
    end

    assign wr_addr = ADDR_W'(wr_ptr) * STRIDE_C + ADDR_W'(wcol);
    assign rd_addr = ADDR_W'(rd_ptr) * STRIDE_C + ADDR_W'(rcol);

    // Pixel RAM with one-cycle registered read
    always_ff @(posedge ACLK) begin
        if (wr_fire) begin
            mem[wr_addr] <= s_data;
        end
        if (rd_fire) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Pointers, columns, occupancy and read-line state
    always_ff @(posedge ACLK) begin
        if (ARESET || !cfg_enable) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wcol     <= '0;
            rcol     <= '0;
            occ      <= '0;
            rd_state <= RD_IDLE;
            s_ready  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                wcol   <= '0;
            end else if (wr_fire) begin
                wcol <= wcol + CNT_W'(1);
            end
            if (consume) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ      <= occ_nxt;
            s_ready  <= (occ_nxt < FULL_C);
            rd_valid <= rd_fire;
            if (rd_line_start) begin
                rcol     <= '0;
                rd_state <= start_next ? RD_LINE : RD_IDLE;
            end else if (rd_fire) begin
                if (rd_last) begin
                    rcol     <= '0;
                    rd_state <= RD_IDLE;
                end else begin
                    rcol <= rcol + CNT_W'(1);
                end
            end
        end
    end

    // Sticky error flags; a set wins over a clear in the same cycle
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            underflow  <= 1'b0;
            rd_abort   <= 1'b0;
            short_line <= 1'b0;
        end else begin
            underflow  <= (uf_set && cfg_enable) ||
                          (underflow && !flag_clr);
            rd_abort   <= (ab_set && cfg_enable) ||
                          (rd_abort && !flag_clr);
            short_line <= short_set || (short_line && !flag_clr);
        end
    end

    assign rd_data     = rd_valid ? ram_q : '0;
    assign lines_avail = occ;

endmodule

// File: doc/vga_line_buffer_mc.md
Name: vga_line_buffer_mc

Overview:
- Parametrised multi-line VGA line buffer: the next generation of the single-line, fixed-width line buffer IP.
- Sits between the pixel producer (a DMA/stream unpacker) and the VGA timing/output stage.
- Stores up to NUM_LINES complete lines in a ring of slots in one block RAM, with runtime-programmable active width.
- Reports occupancy plus sticky underflow, abort and short-line errors for the AXI4-Lite register wrapper to expose.

Parameters:
PIXEL_W, 24, bits per pixel.
MAX_WIDTH, 640, maximum active pixels per line; RAM depth per slot.
NUM_LINES, 4, number of line slots; power of two, >=2.
CNT_W, clog2(MAX_WIDTH+1), width of column counters and cfg_width.
OCC_W, clog2(NUM_LINES+1), width of lines_avail.

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESET  in  1  reset, synchronous and active-high.
cfg_enable  in  1  0 = hold the data path flushed.
cfg_width  in  CNT_W  active pixels per line; a value of 0 or >MAX_WIDTH is used as MAX_WIDTH.
flag_clr  in  1  one-cycle pulse; clears all sticky flags.
s_valid  in  1  write pixel valid.
s_ready  out  1  write pixel ready.
s_data  in  PIXEL_W  write pixel.
s_eol  in  1  last pixel of the line, qualified by s_valid.
rd_line_start  in  1  pulse from the VGA timing block at the start of each active line.
rd_pix_en  in  1  request the next pixel of the current read line.
rd_data  out  PIXEL_W  read pixel; 0 when rd_valid=0.
rd_valid  out  1  rd_data is valid this cycle.
lines_avail  out  OCC_W  committed lines, including the line being read.
underflow  out  1  sticky; rd_line_start arrived with no committed line.
rd_abort  out  1  sticky; rd_line_start arrived before the current line was fully read.
short_line  out  1  sticky; a line was committed by s_eol before cfg_width pixels.

Behaviour:
- Reset values: pointers, wcol, rcol, occupancy and the reading flag = 0; rd_data = 0; rd_valid = 0; s_ready = 0; all sticky flags = 0.
- Effective width W = (cfg_width==0 || cfg_width>MAX_WIDTH) ? MAX_WIDTH : cfg_width.
- cfg_width may change only while cfg_enable=0; a change while enabled gives undefined line lengths but must not hang the block.
- Slot addressing: RAM address = slot*MAX_WIDTH + col; slot indices wrap modulo NUM_LINES.
- Write side:
  - s_ready = cfg_enable && (occ < NUM_LINES), registered from the current state.
  - A pixel is accepted when s_valid && s_ready; it is written to (wr_ptr, wcol) and wcol increments.
  - A line commits on the accepted pixel where wcol==W-1 or s_eol=1, whichever comes first.
  - On commit: wr_ptr++, wcol=0, occ++.
  - If the commit is caused by s_eol with wcol<W-1, short_line is set. The unwritten tail of that slot reads stale data.
  - An s_eol on the pixel where wcol==W-1 is a normal commit.
- Read side:
  - rd_line_start while not reading and occ>0: reading=1, rcol=0, current slot = rd_ptr.
  - rd_line_start while not reading and occ==0: underflow is set; rd_valid stays 0 for that line.
  - rd_line_start while reading: rd_abort is set; the current line is consumed (rd_ptr++, occ--). On the same cycle the next line starts if another committed line remains (occ>1 before consumption); otherwise underflow is also set.
  - rd_pix_en while reading: RAM is read at (rd_ptr, rcol). rd_valid=1 and rd_data follow exactly 1 cycle later.
  - The rd_pix_en with rcol==W-1 ends the line: reading=0, rd_ptr++, occ--. Its pixel is still output on the next cycle.
  - rd_pix_en while not reading is ignored; rd_valid=0 the next cycle.
- Occupancy:
  - Commit and consume in the same cycle leave occ unchanged.
  - lines_avail = occ; it never exceeds NUM_LINES and never underflows.
- Enable: cfg_enable=0 synchronously flushes pointers, wcol, rcol, occ and the reading flag, and drives rd_valid=0. Flags are kept.
- Flags: flag_clr clears all sticky flags. Setting has priority over a clear in the same cycle.
- ARESET mid-line: every in-flight write or read line is discarded, with no partial commit.

Test Plan:
- W=8, NUM_LINES=4: write 2 lines of pixels 0x10..0x17, 0x20..0x27, no s_eol -> lines_avail=2. Line start + 8 rd_pix_en -> rd_data 0x10..0x17, 1-cycle latency, lines_avail=1.
- Write 4 full lines without reading -> lines_avail=4 and s_ready=0. The 33rd pixel is held until one line is consumed, then s_ready=1.
- rd_line_start with lines_avail=0 -> underflow=1, rd_valid=0 for all 8 pixel requests. flag_clr -> underflow=0.
- Write 5 pixels with s_eol on the 5th -> commit, short_line=1, lines_avail=1; the next line starts at column 0.
- Read line A for 3 pixels, then rd_line_start with line B committed -> rd_abort=1, B pixels are output from column 0, lines_avail drops by 1.
- Commit on the same cycle as the final rd_pix_en of a line -> lines_avail unchanged. ARESET mid-write -> lines_avail=0, s_ready=0 during reset.
